// File: rtl/shake_pkg.sv
// rtl/shake_pkg.sv - shared types and constants for the SHAKE input padding path
package shake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ABSORB  = 2'd1,
        ST_PAD     = 2'd2,
        ST_HANDOFF = 2'd3
    } state_e;

    typedef enum logic {
        MODE_SHAKE128 = 1'b0,
        MODE_SHAKE256 = 1'b1
    } mode_e;

    localparam int RATE128_WORDS = 21;
    localparam int RATE256_WORDS = 17;
    localparam logic [7:0] PAD_DS  = 8'h1F;
    localparam logic [7:0] PAD_END = 8'h80;
    localparam int WORD_W  = 64;
    localparam int BLOCK_W = 1344;

    function automatic logic [4:0] rate_words_f(input mode_e m);
        return (m == MODE_SHAKE256) ? 5'(RATE256_WORDS) : 5'(RATE128_WORDS);
    endfunction

    function automatic logic [7:0] rate_bytes_f(input mode_e m);
        return (m == MODE_SHAKE256) ? 8'(RATE256_WORDS * 8) : 8'(RATE128_WORDS * 8);
    endfunction

endpackage

// File: rtl/byte_lane_mask.sv
// rtl/byte_lane_mask.sv - valid byte count (0..8) to little-endian lane mask
module byte_lane_mask (
    input  logic [3:0] nbytes_i,
    output logic [7:0] mask_o
);

    always_comb begin
        mask_o = '0;
        for (int k = 0; k < 8; k++) begin
            mask_o[k] = (nbytes_i > 4'(k));
        end
    end

endmodule

// File: rtl/input_pad_buffer.sv
// rtl/input_pad_buffer.sv - collects message words into rate blocks and applies SHAKE padding
module input_pad_buffer
    import shake_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [31:0]        msg_len,
    input  logic [WORD_W-1:0]  data_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [BLOCK_W-1:0] block_out,
    output logic               block_valid,
    input  logic               block_ready,
    output logic               last_block,
    output logic               busy
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [31:0]        remaining_q, remaining_d;
    logic [4:0]         word_cnt_q, word_cnt_d;
    logic [7:0]         blk_bytes_q, blk_bytes_d;
    logic [BLOCK_W-1:0] buf_q, buf_d;
    logic               pad_pending_q, pad_pending_d;
    logic               last_q, last_d;

    logic [4:0]        rate_words;
    logic [7:0]        rate_bytes;
    logic [3:0]        take;
    logic [7:0]        lane_mask;
    logic [WORD_W-1:0] lane_bits;
    logic              accept;

    assign rate_words = rate_words_f(mode_q);
    assign rate_bytes = rate_bytes_f(mode_q);
    assign take       = (remaining_q > 32'd8) ? 4'd8 : remaining_q[3:0];

    byte_lane_mask u_mask (
        .nbytes_i (take),
        .mask_o   (lane_mask)
    );

    always_comb begin
        lane_bits = '0;
        for (int k = 0; k < 8; k++) begin
            lane_bits[k*8 +: 8] = {8{lane_mask[k]}};
        end
    end

    assign ready_out   = (state_q == ST_ABSORB) && (word_cnt_q < rate_words) && (remaining_q != 32'd0);
    assign accept      = ready_out && valid_in;
    assign block_valid = (state_q == ST_HANDOFF);
    assign last_block  = (state_q == ST_HANDOFF) && last_q;
    assign busy        = (state_q != ST_IDLE);
    assign block_out   = buf_q;

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        remaining_d   = remaining_q;
        word_cnt_d    = word_cnt_q;
        blk_bytes_d   = blk_bytes_q;
        buf_d         = buf_q;
        pad_pending_d = pad_pending_q;
        last_d        = last_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d        = mode_e'(mode);
                    remaining_d   = msg_len;
                    word_cnt_d    = '0;
                    blk_bytes_d   = '0;
                    buf_d         = '0;
                    pad_pending_d = 1'b0;
                    last_d        = 1'b0;
                    state_d       = (msg_len != 32'd0) ? ST_ABSORB : ST_PAD;
                end
            end
            ST_ABSORB: begin
                if (accept) begin
                    buf_d[{word_cnt_q, 6'd0} +: WORD_W] = data_in & lane_bits;
                    remaining_d = remaining_q - {28'd0, take};
                    word_cnt_d  = word_cnt_q + 5'd1;
                    blk_bytes_d = blk_bytes_q + {4'd0, take};
                    // A completely full block has no room for padding; it goes in a fresh block.
                    if (remaining_d == 32'd0) begin
                        if (blk_bytes_d == rate_bytes) begin
                            state_d       = ST_HANDOFF;
                            last_d        = 1'b0;
                            pad_pending_d = 1'b1;
                        end else begin
                            state_d = ST_PAD;
                        end
                    end else if (word_cnt_d == rate_words) begin
                        state_d = ST_HANDOFF;
                        last_d  = 1'b0;
                    end
                end
            end
            ST_PAD: begin
                buf_d[{blk_bytes_q, 3'd0} +: 8] = buf_q[{blk_bytes_q, 3'd0} +: 8] ^ PAD_DS;
                buf_d[{rate_bytes - 8'd1, 3'd0} +: 8] = buf_d[{rate_bytes - 8'd1, 3'd0} +: 8] ^ PAD_END;
                last_d  = 1'b1;
                state_d = ST_HANDOFF;
            end
            ST_HANDOFF: begin
                if (block_ready) begin
                    buf_d       = '0;
                    word_cnt_d  = '0;
                    blk_bytes_d = '0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (pad_pending_q) begin
                        pad_pending_d = 1'b0;
                        state_d       = ST_PAD;
                    end else begin
                        state_d = ST_ABSORB;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_SHAKE128;
            remaining_q   <= '0;
            word_cnt_q    <= '0;
            blk_bytes_q   <= '0;
            buf_q         <= '0;
            pad_pending_q <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            remaining_q   <= remaining_d;
            word_cnt_q    <= word_cnt_d;
            blk_bytes_q   <= blk_bytes_d;
            buf_q         <= buf_d;
            pad_pending_q <= pad_pending_d;
            last_q        <= last_d;
        end
    end

endmodule

// File: tb/tb_input_pad_buffer.sv
// tb/tb_input_pad_buffer.sv - directed self-checking bench for input_pad_buffer
module tb_input_pad_buffer;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [31:0]   msg_len;
    logic [63:0]   data_in;
    logic          valid_in;
    logic          ready_out;
    logic [1343:0] block_out;
    logic          block_valid;
    logic          block_ready;
    logic          last_block;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_w [21];

    input_pad_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .msg_len     (msg_len),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .last_block  (last_block),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 21; i++) exp_w[i] = '0;
    endtask

    task automatic set_byte(input int b, input logic [7:0] v);
        exp_w[b / 8][(b % 8) * 8 +: 8] = v;
    endtask

    task automatic do_start(input logic m, input logic [31:0] len);
        @(negedge clk);
        mode = m; msg_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d);
        int n;
        @(negedge clk);
        valid_in = 1'b1; data_in = d; n = 0;
        while (!ready_out && n < 50) begin
            @(negedge clk); n++;
        end
        if (!ready_out) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_block();
        int n;
        n = 0;
        @(negedge clk);
        while (!block_valid && n < 50) begin
            @(negedge clk); n++;
        end
        if (!block_valid) check("blk_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_block(input string tag, input logic exp_last);
        for (int i = 0; i < 21; i++)
            check($sformatf("%s_w%0d", tag, i), block_out[i*64 +: 64], exp_w[i]);
        check({tag, "_last"}, 64'(last_block), 64'(exp_last));
        check({tag, "_rdy"}, 64'(ready_out), 64'd0);
    endtask

    task automatic take_block();
        @(negedge clk);
        block_ready = 1'b1;
        @(posedge clk); #1;
        block_ready = 1'b0;
    endtask

    task automatic empty_msg_test(input string tag);
        do_start(1'b0, 32'd0);
        wait_block();
        clear_exp();
        set_byte(0, 8'h1F);
        set_byte(167, 8'h80);
        check_block(tag, 1'b1);
        take_block();
        @(negedge clk);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; msg_len = '0;
        data_in = '0; valid_in = 1'b0; block_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready_out), 64'd0);
        check("rst_bvalid", 64'(block_valid), 64'd0);
        check("rst_last", 64'(last_block), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_block", 64'(|block_out), 64'd0);
        @(negedge clk); rst = 1'b0;

        // SHAKE128 empty message
        empty_msg_test("t1");

        // SHAKE256 three-byte message, upper bytes of data must be masked
        do_start(1'b1, 32'd3);
        send_word(64'hFFFFFFFFFFCCBBAA);
        wait_block();
        clear_exp();
        exp_w[0] = 64'h000000001FCCBBAA;
        set_byte(135, 8'h80);
        check_block("t2", 1'b1);
        take_block();

        // SHAKE128 exactly one full rate: data block then padding-only block, with a stall
        do_start(1'b0, 32'd168);
        for (int i = 0; i < 21; i++) send_word(64'h0101010101010101 * 64'(i + 1));
        wait_block();
        clear_exp();
        for (int i = 0; i < 21; i++) exp_w[i] = 64'h0101010101010101 * 64'(i + 1);
        check_block("t3a", 1'b0);
        valid_in = 1'b1; data_in = 64'hDEADBEEFDEADBEEF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_bv", c), 64'(block_valid), 64'd1);
            check($sformatf("stall%0d_rdy", c), 64'(ready_out), 64'd0);
            check($sformatf("stall%0d_w0", c), block_out[63:0], exp_w[0]);
            check($sformatf("stall%0d_w20", c), block_out[1343:1280], exp_w[20]);
        end
        valid_in = 1'b0;
        take_block();
        wait_block();
        clear_exp();
        set_byte(0, 8'h1F);
        set_byte(167, 8'h80);
        check_block("t3b", 1'b1);
        take_block();

        // SHAKE256 135 bytes: padding collapses into the final byte as 0x9F
        do_start(1'b1, 32'd135);
        for (int i = 0; i < 16; i++) send_word(64'h1111111111111111 * 64'(i + 1));
        send_word(64'hEEDDCCBBAA998877);
        wait_block();
        clear_exp();
        for (int i = 0; i < 16; i++) exp_w[i] = 64'h1111111111111111 * 64'(i + 1);
        exp_w[16] = 64'h9FDDCCBBAA998877;
        check_block("t4", 1'b1);
        take_block();

        // Reset in the middle of absorbing
        do_start(1'b0, 32'd100);
        for (int i = 0; i < 5; i++) send_word(64'hCAFEF00D00000000 | 64'(i));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(ready_out), 64'd0);
        check("mid_rst_bvalid", 64'(block_valid), 64'd0);
        check("mid_rst_last", 64'(last_block), 64'd0);
        check("mid_rst_block", 64'(|block_out), 64'd0);
        @(negedge clk); rst = 1'b0;
        empty_msg_test("t5");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_pad_buffer.md
INPUT_PAD_BUFFER -- requirements
Module: input_pad_buffer

Interface
REQ-001 SHALL have port: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start  in  1  begin a new message, sampled in IDLE only.
REQ-004 SHALL have port: mode  in  1  0=SHAKE128 (rate 21 words/168 B), 1=SHAKE256 (rate 17 words/136 B), latched on start.
REQ-005 SHALL have port: msg_len  in  32  message length in bytes, latched on start.
REQ-006 SHALL have port: data_in  in  64  message word, byte k at bits 8k+7:8k (little-endian).
REQ-007 SHALL have ports: valid_in  in  1  data_in valid; ready_out  out  1  word accepted when valid_in&ready_out.
REQ-008 SHALL have port: block_out  out  1344  rate block, word i at bits 64i+63:64i; bits above rate are zero.
REQ-009 SHALL have ports: block_valid  out  1  block presented; block_ready  in  1  permutation core accepts.
REQ-010 SHALL have ports: last_block  out  1  qualifies block_valid, final padded block; busy  out  1  not IDLE.

Function
REQ-011 SHALL implement states IDLE, ABSORB, PAD, HANDOFF.
REQ-012 IDLE: on start, SHALL latch mode and msg_len, set remaining=msg_len, word_cnt=0, clear buffer, pad_pending=0; next ABSORB if msg_len>0, else PAD.
REQ-013 ABSORB: ready_out SHALL be 1 iff word_cnt<rate_words and remaining>0.
REQ-014 On accept, SHALL write data_in to slot word_cnt with bytes at index>=remaining forced to 0, then remaining-=min(8,remaining), word_cnt+=1.
REQ-015 After accept: remaining=0 and word_cnt<rate_words -> PAD; word_cnt=rate_words and remaining>0 -> HANDOFF, last=0; remaining=0 and word_cnt=rate_words -> HANDOFF, last=0, pad_pending=1.
REQ-016 PAD (exactly one cycle): SHALL XOR 0x1F into byte p=(bytes absorbed in current block) and 0x80 into byte rate_bytes-1; p=rate_bytes-1 yields 0x9F; next HANDOFF with last=1.
REQ-017 HANDOFF: block_valid=1, block_out and last_block SHALL be stable until block_ready; ready_out=0.
REQ-018 On block_valid&block_ready: clear buffer, word_cnt=0; last=1 -> IDLE; pad_pending=1 -> clear pad_pending, PAD; else ABSORB.
REQ-019 block_valid SHALL not depend combinationally on block_ready; ready_out SHALL not depend on valid_in.
REQ-020 start outside IDLE SHALL be ignored; valid_in outside ABSORB SHALL be ignored.
REQ-021 remaining/msg_len SHALL be 32-bit unsigned; no wrap (saturating min subtraction).

Reset
REQ-022 rst SHALL force IDLE and zero buffer, counters, pad_pending, last flag, from any state including mid-ABSORB/HANDOFF.
REQ-023 Reset values: ready_out=0, block_valid=0, last_block=0, busy=0, block_out=0.

Structure
REQ-024 shake_pkg SHALL hold state enum, mode enum, RATE128_WORDS=21, RATE256_WORDS=17, PAD_DS=8'h1F, PAD_END=8'h80, WORD_W=64, BLOCK_W=1344.
REQ-025 Byte-mask/pad-position logic SHALL be one sub-module, byte_lane_mask (valid byte count -> 8-bit lane mask).

Verification
REQ-026 SHAKE128, msg_len=0 -> one block: byte0=0x1F, byte167=0x80, others 0, last_block=1.
REQ-027 SHAKE256, msg_len=3, data_in=0xFFFFFFFFFFCCBBAA -> word0=0x000000001FCCBBAA, byte135=0x80, bits above 1087 zero, last=1.
REQ-028 SHAKE128, msg_len=168 -> block1: 21 data words, last=0; block2: byte0=0x1F, byte167=0x80, last=1.
REQ-029 SHAKE256, msg_len=135 -> single block, byte134=data, byte135=0x9F, last=1.
REQ-030 block_ready low 10 cycles in HANDOFF -> block_valid=1, block_out unchanged, ready_out=0 throughout.
REQ-031 rst pulsed after 5 words accepted -> next cycle IDLE, all outputs 0; fresh start then behaves as REQ-026.
